// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared types and constants for the wall-following maze solver.
//  - state_t / state constants : solver FSM encoding
//  - HDNG_* constants          : the four compass headings on the 12-bit scale
//  - turn_t                    : turn request produced by the decision step
//  - next_hdng()               : heading lookup for a turn (pure table, no math)
// ---------------------------------------------------------------------------
package maze_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t STRT_MV   = 3'd1;
  localparam state_t WAIT_MV   = 3'd2;
  localparam state_t DECIDE    = 3'd3;
  localparam state_t STRT_HDNG = 3'd4;
  localparam state_t WAIT_HDNG = 3'd5;
  localparam state_t DONE      = 3'd6;

  typedef logic [11:0] hdng_t;

  localparam hdng_t HDNG_N = 12'h000;
  localparam hdng_t HDNG_W = 12'h3FF;
  localparam hdng_t HDNG_S = 12'h7FF;
  localparam hdng_t HDNG_E = 12'hC00;

  typedef enum logic [1:0] {TURN_L, TURN_R, TURN_180} turn_t;

  // Unknown headings pass through unchanged so a host-set odd heading is
  // never silently snapped to a compass point.
  function automatic hdng_t next_hdng(input hdng_t hdng, input turn_t turn);
    hdng_t res;
    res = hdng;
    case (hdng)
      HDNG_N: case (turn)
        TURN_L:  res = HDNG_W;
        TURN_R:  res = HDNG_E;
        default: res = HDNG_S;
      endcase
      HDNG_W: case (turn)
        TURN_L:  res = HDNG_S;
        TURN_R:  res = HDNG_N;
        default: res = HDNG_E;
      endcase
      HDNG_S: case (turn)
        TURN_L:  res = HDNG_E;
        TURN_R:  res = HDNG_W;
        default: res = HDNG_N;
      endcase
      HDNG_E: case (turn)
        TURN_L:  res = HDNG_N;
        TURN_R:  res = HDNG_S;
        default: res = HDNG_W;
      endcase
      default: res = hdng;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/maze_solver_if.sv
// ---------------------------------------------------------------------------
// maze_solver_if
// Navigation bundle between the solver and the navigation datapath.
//  master : solver side (drives heading/move requests and stop selects)
//  slave  : datapath / command-mode side (drives mode, sensors, completions)
// Signals:
//  cmd_md, lft_affn, lft_opn, rght_opn, mv_cmplt, sol_cmplt  -> solver
//  strt_hdng, strt_mv, dsrd_hdng, stp_lft, stp_rght, sol_fail <- solver
// ---------------------------------------------------------------------------
interface maze_solver_if;
  import maze_pkg::*;

  logic  cmd_md;
  logic  lft_affn;
  logic  lft_opn;
  logic  rght_opn;
  logic  mv_cmplt;
  logic  sol_cmplt;
  logic  strt_hdng;
  logic  strt_mv;
  hdng_t dsrd_hdng;
  logic  stp_lft;
  logic  stp_rght;
  logic  sol_fail;

  modport master (
    input  cmd_md, lft_affn, lft_opn, rght_opn, mv_cmplt, sol_cmplt,
    output strt_hdng, strt_mv, dsrd_hdng, stp_lft, stp_rght, sol_fail
  );

  modport slave (
    output cmd_md, lft_affn, lft_opn, rght_opn, mv_cmplt, sol_cmplt,
    input  strt_hdng, strt_mv, dsrd_hdng, stp_lft, stp_rght, sol_fail
  );

endinterface

// File: rtl/maze_solver.sv
// ---------------------------------------------------------------------------
// maze_solver
// Autonomous wall-following sequencer. While cmd_md=0 it alternates forward
// moves and heading changes, choosing each turn from the side-opening
// sensors captured at move completion (left- or right-hand rule). Stops on
// sol_cmplt; yields to the host when cmd_md=1.
// Ports:
//  clk    : system clock
//  rst_n  : asynchronous active-low reset
//  nav    : maze_solver_if.master (mode, sensors, completions in;
//           strt_hdng/strt_mv pulses, dsrd_hdng, stp_lft/stp_rght, sol_fail out)
// Parameter:
//  MAX_MOVES : move-request limit (only with MAZE_MOVE_LIMIT_EN)
// Optional feature: define MAZE_MOVE_LIMIT_EN to enable the move-limit abort
// (sol_fail); otherwise sol_fail is tied low and no counter exists.
// ---------------------------------------------------------------------------
module maze_solver
  import maze_pkg::*;
#(
  parameter int MAX_MOVES = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  maze_solver_if.master nav
);

  state_t state;
  logic   affn_q;
  logic   lft_opn_p0;
  logic   rght_opn_p0;
  hdng_t  hdng_q;
  logic   stp_lft_q;
  logic   stp_rght_q;
  turn_t  turn;

`ifdef MAZE_MOVE_LIMIT_EN
  localparam logic [9:0] MAX_CNT = 10'(MAX_MOVES);
  logic [9:0] mv_cnt;
  logic       sol_fail_q;
  logic       at_limit;

  assign at_limit = (mv_cnt == MAX_CNT);
`endif

  // Stage p0: wall openings captured on move completion
  always_ff @(posedge clk) begin
    if (state == WAIT_MV && nav.mv_cmplt) begin
      lft_opn_p0  <= nav.lft_opn;
      rght_opn_p0 <= nav.rght_opn;
    end
  end

  // Preferred side first, then the other side, otherwise turn around.
  always_comb begin
    turn = TURN_180;
    if (affn_q) begin
      if (lft_opn_p0)       turn = TURN_L;
      else if (rght_opn_p0) turn = TURN_R;
    end else begin
      if (rght_opn_p0)      turn = TURN_R;
      else if (lft_opn_p0)  turn = TURN_L;
    end
  end

  // Host takeover outranks goal detection; both outrank normal sequencing,
  // so sol_cmplt beats a same-cycle mv_cmplt and no heading update leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hdng_q     <= HDNG_N;
      stp_lft_q  <= 1'b0;
      stp_rght_q <= 1'b0;
      affn_q     <= 1'b1;
`ifdef MAZE_MOVE_LIMIT_EN
      mv_cnt     <= '0;
      sol_fail_q <= 1'b0;
`endif
    end else if (state != IDLE && state != DONE && nav.cmd_md) begin
      state      <= IDLE;
`ifdef MAZE_MOVE_LIMIT_EN
      sol_fail_q <= 1'b0;
`endif
    end else if (state != IDLE && state != DONE && nav.sol_cmplt) begin
      state <= DONE;
    end else begin
      case (state)
        IDLE: begin
`ifdef MAZE_MOVE_LIMIT_EN
          mv_cnt <= '0;
`endif
          if (!nav.cmd_md) begin
            affn_q     <= nav.lft_affn;
            stp_lft_q  <= nav.lft_affn;
            stp_rght_q <= !nav.lft_affn;
            state      <= STRT_MV;
          end
        end
        STRT_MV: begin
`ifdef MAZE_MOVE_LIMIT_EN
          if (at_limit) begin
            sol_fail_q <= 1'b1;
            state      <= DONE;
          end else begin
            mv_cnt <= mv_cnt + 10'd1;
            state  <= WAIT_MV;
          end
`else
          state <= WAIT_MV;
`endif
        end
        WAIT_MV:   if (nav.mv_cmplt) state <= DECIDE;
        DECIDE: begin
          hdng_q <= next_hdng(hdng_q, turn);
          state  <= STRT_HDNG;
        end
        STRT_HDNG: state <= WAIT_HDNG;
        WAIT_HDNG: if (nav.mv_cmplt) state <= STRT_MV;
        DONE: begin
          if (nav.cmd_md) begin
            state <= IDLE;
`ifdef MAZE_MOVE_LIMIT_EN
            sol_fail_q <= 1'b0;
`endif
          end
        end
        default:   state <= IDLE;
      endcase
    end
  end

  // Request pulses decode straight from state: exactly one cycle each and
  // mutually exclusive by construction.
  assign nav.strt_hdng = (state == STRT_HDNG);
  assign nav.dsrd_hdng = hdng_q;
  assign nav.stp_lft   = stp_lft_q;
  assign nav.stp_rght  = stp_rght_q;

`ifdef MAZE_MOVE_LIMIT_EN
  assign nav.strt_mv  = (state == STRT_MV) && !at_limit;
  assign nav.sol_fail = sol_fail_q;
`else
  logic [31:0] unused_max_moves;
  assign unused_max_moves = 32'(MAX_MOVES);
  assign nav.strt_mv  = (state == STRT_MV);
  assign nav.sol_fail = 1'b0;
`endif

endmodule

// File: tb/tb_maze_solver.sv
// ---------------------------------------------------------------------------
// tb_maze_solver
// Scoreboard bench for maze_solver. Stimulus tasks act as the navigation
// datapath and push the expected request pulses (kind, heading, stop
// selects, cycle) predicted by a compass-index model; an independent
// monitor pops and compares every pulse the solver emits.
// ---------------------------------------------------------------------------
module tb_maze_solver;

`ifdef MAZE_MOVE_LIMIT_EN
  localparam int TB_MAX   = 3;
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam int TB_MAX   = 1023;
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_MV   = 1;
  localparam int P_HD   = 2;
  localparam int P_DONE = 3;

  typedef struct {
    bit          is_hdng;
    logic [11:0] hdng;
    bit          sl;
    bit          sr;
    int          at;
  } exp_t;

  logic clk;
  logic rst_n;
  maze_solver_if bus();

  maze_solver #(.MAX_MOVES(TB_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .nav   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int total;
  int bad;
  int pulses_seen;
  int mv_pulses;
  exp_t exp_q[$];
  exp_t mon_e;

  // Compass order N, W, S, E: a left turn is +1, right +3, reverse +2.
  logic [11:0] HV [4] = '{12'h000, 12'h3FF, 12'h7FF, 12'hC00};
  int m_idx;
  int m_phase;
  int m_moves;
  bit m_affn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.strt_mv || bus.strt_hdng)) begin
      pulses_seen++;
      if (bus.strt_mv) mv_pulses++;
      if (bus.strt_mv && bus.strt_hdng) check("pulse_overlap", 1, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {bus.strt_hdng, bus.strt_mv}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind",  bus.strt_hdng, mon_e.is_hdng);
        check("dsrd_hdng",   bus.dsrd_hdng, mon_e.hdng);
        check("stp_lft",     bus.stp_lft,   mon_e.sl);
        check("stp_rght",    bus.stp_rght,  mon_e.sr);
        check("pulse_cycle", cyc,           mon_e.at);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_idx   = 0;
    m_phase = P_IDLE;
    m_moves = 0;
    m_affn  = 1'b1;
    exp_q.delete();
  endtask

  // Returns 1 when the request is refused by the move limit.
  function automatic bit expect_mv(input int at);
    exp_t e;
    if (LIMIT_EN && m_moves == TB_MAX) begin
      m_phase = P_DONE;
      return 1'b1;
    end
    m_moves++;
    e.is_hdng = 1'b0;
    e.hdng    = HV[m_idx];
    e.sl      = m_affn;
    e.sr      = !m_affn;
    e.at      = at;
    exp_q.push_back(e);
    m_phase = P_MV;
    return 1'b0;
  endfunction

  task automatic wait_pulse(input int base);
    if (exp_q.size() == 0) return;
    for (int k = 0; k < 12 && pulses_seen == base; k++) begin
      @(negedge clk);
      #1;
    end
    if (pulses_seen == base) begin
      check("pulse_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_strt_mv"},   bus.strt_mv,   0);
    check({tag, "_strt_hdng"}, bus.strt_hdng, 0);
    check({tag, "_dsrd_hdng"}, bus.dsrd_hdng, 12'h000);
    check({tag, "_stp_lft"},   bus.stp_lft,   0);
    check({tag, "_stp_rght"},  bus.stp_rght,  0);
    check({tag, "_sol_fail"},  bus.sol_fail,  0);
  endtask

  task automatic start(input bit affn);
    int base;
    bit refused;
    tick();
    bus.lft_affn = affn;
    bus.cmd_md   = 1'b0;
    base = pulses_seen;
    m_affn  = affn;
    m_moves = 0;
    refused = expect_mv(cyc + 1);
    wait_pulse(base);
  endtask

  task automatic complete(input bit lo, input bit ro);
    int base;
    bit refused;
    exp_t e;
    refused = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    tick();
    bus.mv_cmplt = 1'b1;
    bus.lft_opn  = lo;
    bus.rght_opn = ro;
    base = pulses_seen;
    if (m_phase == P_MV) begin
      if (m_affn ? lo : ro)      m_idx = (m_idx + (m_affn ? 1 : 3)) % 4;
      else if (m_affn ? ro : lo) m_idx = (m_idx + (m_affn ? 3 : 1)) % 4;
      else                       m_idx = (m_idx + 2) % 4;
      e.is_hdng = 1'b1;
      e.hdng    = HV[m_idx];
      e.sl      = m_affn;
      e.sr      = !m_affn;
      e.at      = cyc + 2;
      exp_q.push_back(e);
      m_phase = P_HD;
    end else if (m_phase == P_HD) begin
      refused = expect_mv(cyc + 1);
    end
    tick();
    bus.mv_cmplt = 1'b0;
    bus.lft_opn  = 1'($urandom_range(0, 1));
    bus.rght_opn = 1'($urandom_range(0, 1));
    if (refused) begin
      tick();
      check("sol_fail_set", bus.sol_fail, 1);
    end
    wait_pulse(base);
  endtask

  task automatic go_host();
    tick();
    bus.cmd_md = 1'b1;
    m_phase = P_IDLE;
    tick();
    check("sol_fail_idle", bus.sol_fail, 0);
  endtask

  task automatic finish_sol();
    tick();
    bus.sol_cmplt = 1'b1;
    tick();
    bus.sol_cmplt = 1'b0;
    m_phase = P_DONE;
    repeat (3) tick();
  endtask

  initial begin
    int base;
    bus.cmd_md    = 1'b1;
    bus.lft_affn  = 1'b1;
    bus.lft_opn   = 1'b0;
    bus.rght_opn  = 1'b0;
    bus.mv_cmplt  = 1'b0;
    bus.sol_cmplt = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Left-hand start, both sides open -> left turn N to W
    start(1'b1);
    check("start_stp_lft",  bus.stp_lft,  1);
    check("start_stp_rght", bus.stp_rght, 0);
    check("start_hdng",     bus.dsrd_hdng, 12'h000);
    complete(1'b1, 1'b1);
    complete(1'b0, 1'b0);
    complete(1'b1, 1'b0);
    complete(1'b0, 1'b0);
    complete(1'b1, 1'b0);
    complete(1'b0, 1'b0);
    check("heading_east", bus.dsrd_hdng, 12'hC00);

    // Right-hand rule facing E, dead end -> reverse to W
    go_host();
    start(1'b0);
    complete(1'b0, 1'b0);
    complete(1'b1, 1'b1);

    // Goal and completion in the same cycle: goal wins, no more requests
    tick();
    bus.mv_cmplt  = 1'b1;
    bus.sol_cmplt = 1'b1;
    base = pulses_seen;
    m_phase = P_DONE;
    tick();
    bus.mv_cmplt  = 1'b0;
    bus.sol_cmplt = 1'b0;
    repeat (4) tick();
    bus.mv_cmplt = 1'b1;
    tick();
    bus.mv_cmplt = 1'b0;
    repeat (4) tick();
    check("done_no_pulse", pulses_seen, base);
    check("done_hdng_held", bus.dsrd_hdng, HV[m_idx]);
    go_host();

    // Back from DONE; right side only open under left-hand rule -> right turn
    start(1'b1);
    complete(1'b0, 1'b1);

    // Host takeover while waiting on the heading change
    tick();
    bus.cmd_md = 1'b1;
    m_phase = P_IDLE;
    tick();
    bus.mv_cmplt = 1'b1;
    base = pulses_seen;
    tick();
    bus.mv_cmplt = 1'b0;
    repeat (5) tick();
    check("host_no_pulse", pulses_seen, base);
    check("host_hdng_kept", bus.dsrd_hdng, HV[m_idx]);

    // Reset in the middle of a move
    start(1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    model_reset();
    bus.cmd_md = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start(1'b1);
    complete(1'b1, 1'b0);
    complete(1'b0, 1'b0);
    go_host();

`ifdef MAZE_MOVE_LIMIT_EN
    base = mv_pulses;
    start(1'b1);
    repeat (10) complete(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("limit_mv_pulses", mv_pulses - base, TB_MAX);
    check("limit_sol_fail", bus.sol_fail, 1);
    go_host();
`endif

    // Randomized wandering with occasional host takeovers
    for (int r = 0; r < 6; r++) begin
      start(1'($urandom_range(0, 1)));
      for (int i = 0; i < 24; i++) begin
        if ($urandom_range(0, 9) == 0 && (m_phase == P_MV || m_phase == P_HD)) begin
          go_host();
          start(1'($urandom_range(0, 1)));
        end else begin
          complete(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      finish_sol();
      go_host();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
